// File: rtl/pic_irq_priority_pkg.sv
// pic_irq_priority_pkg: shared FSM states, INTA phases and priority helpers for the PIC priority stage
package pic_irq_priority_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_SECOND} state_t;
  localparam logic [1:0] INTA_IDLE = 2'd0;
  localparam logic [1:0] INTA_FIRST = 2'd1;
  localparam logic [1:0] INTA_SECOND = 2'd2;
  localparam logic [2:0] SPURIOUS_LVL = 3'd7;
  localparam logic [2:0] RESET_LP = 3'd7;
  // 0 = highest priority, 7 = lowest, relative to the lowest-priority pointer
  function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lp);
    return lvl - lp - 3'd1;
  endfunction
  function automatic logic [7:0] bit8(input logic [2:0] n);
    return 8'd1 << n;
  endfunction
endpackage

// File: rtl/pic_irq_priority_if.sv
// pic_irq_priority_if: control-unit facing signals of the PIC priority stage
interface pic_irq_priority_if;
  logic [7:0] ir;
  logic level;
  logic [7:0] interrupt_mask;
  logic r;
  logic aeoi;
  logic [1:0] inta_count;
  logic eoi_stb;
  logic eoi_specific;
  logic [2:0] eoi_level;
  logic internal_int;
  logic [2:0] ir_num;
  logic [7:0] irr;
  logic [7:0] isr;
  modport master (
    output ir, level, interrupt_mask, r, aeoi, inta_count, eoi_stb, eoi_specific, eoi_level,
    input internal_int, ir_num, irr, isr
  );
  modport slave (
    input ir, level, interrupt_mask, r, aeoi, inta_count, eoi_stb, eoi_specific, eoi_level,
    output internal_int, ir_num, irr, isr
  );
endinterface

// File: rtl/pic_irq_priority_resolve.sv
// pic_prio_resolve8: rotated find-first-set, level (lp+1) mod 8 is highest priority
module pic_prio_resolve8 (
  input logic [7:0] i_vec,
  input logic [2:0] i_lp,
  output logic o_valid,
  output logic [2:0] o_lvl
);
  // scan lowest to highest priority so the last hit is the winner
  always_comb begin
    o_valid = 1'b0;
    o_lvl = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (i_vec[3'(i_lp + 3'(k))]) begin
        o_valid = 1'b1;
        o_lvl = 3'(i_lp + 3'(k));
      end
    end
  end
endmodule

// File: rtl/pic_irq_priority.sv
// pic_irq_priority: 8259-style IRR/ISR/priority stage with INTA sequencing and EOI handling
module pic_irq_priority
  import pic_irq_priority_pkg::*;
(
  input logic clk,
  input logic rst,
  pic_irq_priority_if.slave bus
);
  state_t r_state;
  logic [7:0] r_irr, r_isr, r_ir_prev;
  logic [2:0] r_ir_num, r_lp;
  logic r_int, r_spur;
  logic w_cand_valid, w_isv_valid, w_req, w_latch, w_set, w_eoi_hit, w_aeoi_hit;
  logic [2:0] w_cand, w_isv, w_eoi_lvl, w_lp_n;
  logic [7:0] w_irr_n, w_isr_n;
  pic_prio_resolve8 u_cand (
    .i_vec(r_irr & ~bus.interrupt_mask), .i_lp(r_lp), .o_valid(w_cand_valid), .o_lvl(w_cand)
  );
  pic_prio_resolve8 u_isv (
    .i_vec(r_isr), .i_lp(r_lp), .o_valid(w_isv_valid), .o_lvl(w_isv)
  );
  assign w_req = w_cand_valid && (!w_isv_valid || prio_rank(w_cand, r_lp) < prio_rank(w_isv, r_lp));
  assign w_latch = r_state == ST_IDLE && bus.inta_count == INTA_FIRST;
  assign w_set = w_latch && w_cand_valid;
  assign w_eoi_lvl = bus.eoi_specific ? bus.eoi_level : w_isv;
  assign w_eoi_hit = bus.eoi_stb && (bus.eoi_specific ? r_isr[bus.eoi_level] : w_isv_valid);
  assign w_aeoi_hit = r_state == ST_FIRST && bus.inta_count == INTA_SECOND && bus.aeoi && !r_spur;
  // a falling request line withdraws a pending edge request as well
  assign w_irr_n = (bus.level ? bus.ir : (r_irr | (bus.ir & ~r_ir_prev)) & bus.ir)
                   & ~(w_set ? bit8(w_cand) : 8'd0);
  // EOI acts on the pre-latch ISR; the latch set is applied last so it wins
  assign w_isr_n = (r_isr & ~(w_eoi_hit ? bit8(w_eoi_lvl) : 8'd0) & ~(w_aeoi_hit ? bit8(r_ir_num) : 8'd0))
                   | (w_set ? bit8(w_cand) : 8'd0);
  assign w_lp_n = (bus.r && w_aeoi_hit) ? r_ir_num : (bus.r && w_eoi_hit) ? w_eoi_lvl : r_lp;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_irr <= 8'd0;
      r_isr <= 8'd0;
      r_ir_prev <= 8'd0;
      r_ir_num <= SPURIOUS_LVL;
      r_lp <= RESET_LP;
      r_int <= 1'b0;
      r_spur <= 1'b0;
    end else begin
      r_state <= bus.inta_count == INTA_IDLE ? ST_IDLE
               : w_latch ? ST_FIRST
               : (r_state == ST_FIRST && bus.inta_count == INTA_SECOND) ? ST_SECOND
               : r_state;
      r_irr <= w_irr_n;
      r_isr <= w_isr_n;
      r_ir_prev <= bus.ir;
      r_lp <= w_lp_n;
      r_int <= w_req && !w_latch;
      if (w_latch) begin
        r_ir_num <= w_cand_valid ? w_cand : SPURIOUS_LVL;
        r_spur <= !w_cand_valid;
      end
    end
  end
  assign bus.internal_int = r_int;
  assign bus.ir_num = r_ir_num;
  assign bus.irr = r_irr;
  assign bus.isr = r_isr;
endmodule

// File: tb/tb_pic_irq_priority.sv
// tb_pic_irq_priority: directed scenario tests for the PIC priority stage
module tb_pic_irq_priority;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  pic_irq_priority_if bus();
  pic_irq_priority dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.ir = 8'h00; bus.level = 1'b0; bus.interrupt_mask = 8'h00; bus.r = 1'b0; bus.aeoi = 1'b0;
    bus.inta_count = 2'd0; bus.eoi_stb = 1'b0; bus.eoi_specific = 1'b0; bus.eoi_level = 3'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic ack();
    bus.inta_count = 2'd1; tick();
    bus.inta_count = 2'd2; tick();
    bus.inta_count = 2'd0; tick();
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl);
    bus.eoi_stb = 1'b1; bus.eoi_specific = spec; bus.eoi_level = lvl; tick();
    bus.eoi_stb = 1'b0; bus.eoi_specific = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.irr !== 8'h00) begin fails++; $display("FAIL reset_irr: got %h want 00", bus.irr); end
    checks++; if (bus.isr !== 8'h00) begin fails++; $display("FAIL reset_isr: got %h want 00", bus.isr); end
    checks++; if (bus.ir_num !== 3'd7) begin fails++; $display("FAIL reset_ir_num: got %0d want 7", bus.ir_num); end
    checks++; if (bus.internal_int !== 1'b0) begin fails++; $display("FAIL reset_int: got %b want 0", bus.internal_int); end
  endtask

  task automatic test_basic_edge();
    do_reset();
    bus.ir = 8'h24; tick();
    checks++; if (bus.irr !== 8'h24) begin fails++; $display("FAIL basic_irr: got %h want 24", bus.irr); end
    tick();
    checks++; if (bus.internal_int !== 1'b1) begin fails++; $display("FAIL basic_int: got %b want 1", bus.internal_int); end
    bus.inta_count = 2'd1; tick();
    checks++; if (bus.ir_num !== 3'd2) begin fails++; $display("FAIL basic_ir_num: got %0d want 2", bus.ir_num); end
    checks++; if (bus.isr !== 8'h04) begin fails++; $display("FAIL basic_isr: got %h want 04", bus.isr); end
    checks++; if (bus.irr !== 8'h20) begin fails++; $display("FAIL basic_irr_clr: got %h want 20", bus.irr); end
    checks++; if (bus.internal_int !== 1'b0) begin fails++; $display("FAIL basic_int_clr: got %b want 0", bus.internal_int); end
    bus.inta_count = 2'd2; tick();
    bus.inta_count = 2'd0; tick();
    eoi(1'b0, 3'd0);
    checks++; if (bus.isr !== 8'h00) begin fails++; $display("FAIL basic_eoi_isr: got %h want 00", bus.isr); end
    tick();
    checks++; if (bus.internal_int !== 1'b1) begin fails++; $display("FAIL basic_reassert: got %b want 1", bus.internal_int); end
  endtask

  task automatic test_nesting();
    do_reset();
    bus.ir = 8'h04; tick(2);
    ack();
    bus.ir = 8'h06; tick(2);
    checks++; if (bus.internal_int !== 1'b1) begin fails++; $display("FAIL nest_higher: got %b want 1", bus.internal_int); end
    bus.ir = 8'h04; tick();
    bus.ir = 8'h44; tick(3);
    checks++; if (bus.irr !== 8'h40) begin fails++; $display("FAIL nest_irr: got %h want 40", bus.irr); end
    checks++; if (bus.internal_int !== 1'b0) begin fails++; $display("FAIL nest_lower: got %b want 0", bus.internal_int); end
  endtask

  task automatic test_mask();
    do_reset();
    bus.interrupt_mask = 8'h40; bus.ir = 8'h40; tick(3);
    checks++; if (bus.irr !== 8'h40) begin fails++; $display("FAIL mask_irr: got %h want 40", bus.irr); end
    checks++; if (bus.internal_int !== 1'b0) begin fails++; $display("FAIL mask_int: got %b want 0", bus.internal_int); end
    bus.interrupt_mask = 8'h00; tick();
    checks++; if (bus.internal_int !== 1'b1) begin fails++; $display("FAIL unmask_int: got %b want 1", bus.internal_int); end
  endtask

  task automatic test_aeoi_rotate();
    do_reset();
    bus.aeoi = 1'b1; bus.r = 1'b1;
    bus.ir = 8'h08; tick(2);
    bus.inta_count = 2'd1; tick();
    checks++; if (bus.isr !== 8'h08) begin fails++; $display("FAIL aeoi_isr_set: got %h want 08", bus.isr); end
    bus.inta_count = 2'd2; tick();
    checks++; if (bus.isr !== 8'h00) begin fails++; $display("FAIL aeoi_isr_clr: got %h want 00", bus.isr); end
    bus.inta_count = 2'd0; tick();
    bus.ir = 8'h14; tick(2);
    checks++; if (bus.internal_int !== 1'b1) begin fails++; $display("FAIL rot_int: got %b want 1", bus.internal_int); end
    bus.inta_count = 2'd1; tick();
    checks++; if (bus.ir_num !== 3'd4) begin fails++; $display("FAIL rot_ir_num: got %0d want 4", bus.ir_num); end
    checks++; if (bus.isr !== 8'h10) begin fails++; $display("FAIL rot_isr: got %h want 10", bus.isr); end
    bus.inta_count = 2'd2; tick();
    bus.inta_count = 2'd0; tick();
  endtask

  task automatic test_spurious();
    do_reset();
    bus.ir = 8'h01; tick(2);
    bus.inta_count = 2'd1; tick();
    checks++; if (bus.ir_num !== 3'd0) begin fails++; $display("FAIL pre_spur_ir_num: got %0d want 0", bus.ir_num); end
    bus.inta_count = 2'd2; tick();
    bus.inta_count = 2'd0; tick();
    eoi(1'b0, 3'd0);
    bus.ir = 8'h21; tick();
    checks++; if (bus.irr !== 8'h20) begin fails++; $display("FAIL spur_irr_set: got %h want 20", bus.irr); end
    bus.ir = 8'h01; tick();
    bus.inta_count = 2'd1; tick();
    checks++; if (bus.ir_num !== 3'd7) begin fails++; $display("FAIL spur_ir_num: got %0d want 7", bus.ir_num); end
    checks++; if (bus.isr !== 8'h00) begin fails++; $display("FAIL spur_isr: got %h want 00", bus.isr); end
    bus.inta_count = 2'd2; tick();
    bus.inta_count = 2'd0; tick();
  endtask

  task automatic test_level();
    do_reset();
    bus.level = 1'b1; bus.ir = 8'h08; tick(2);
    checks++; if (bus.internal_int !== 1'b1) begin fails++; $display("FAIL level_int: got %b want 1", bus.internal_int); end
    bus.inta_count = 2'd1; tick();
    checks++; if (bus.irr !== 8'h00) begin fails++; $display("FAIL level_irr_clr: got %h want 00", bus.irr); end
    bus.inta_count = 2'd2; tick();
    bus.inta_count = 2'd0; tick();
    checks++; if (bus.irr !== 8'h08) begin fails++; $display("FAIL level_irr_reset: got %h want 08", bus.irr); end
    checks++; if (bus.internal_int !== 1'b0) begin fails++; $display("FAIL level_int_hold: got %b want 0", bus.internal_int); end
    eoi(1'b0, 3'd0);
    tick();
    checks++; if (bus.internal_int !== 1'b1) begin fails++; $display("FAIL level_reassert: got %b want 1", bus.internal_int); end
  endtask

  task automatic test_specific_eoi();
    do_reset();
    bus.ir = 8'h08; tick(2);
    ack();
    bus.ir = 8'h0A; tick(2);
    bus.inta_count = 2'd1; tick();
    checks++; if (bus.isr !== 8'h0A) begin fails++; $display("FAIL spec_isr_pre: got %h want 0a", bus.isr); end
    bus.inta_count = 2'd2; tick();
    bus.inta_count = 2'd0; tick();
    eoi(1'b1, 3'd3);
    checks++; if (bus.isr !== 8'h02) begin fails++; $display("FAIL spec_eoi_isr: got %h want 02", bus.isr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.ir = 8'h04; tick(2);
    bus.inta_count = 2'd1; tick();
    rst = 1'b1; #1;
    checks++; if (bus.ir_num !== 3'd7) begin fails++; $display("FAIL mid_rst_ir_num: got %0d want 7", bus.ir_num); end
    checks++; if (bus.isr !== 8'h00) begin fails++; $display("FAIL mid_rst_isr: got %h want 00", bus.isr); end
    checks++; if (bus.irr !== 8'h00) begin fails++; $display("FAIL mid_rst_irr: got %h want 00", bus.irr); end
    checks++; if (bus.internal_int !== 1'b0) begin fails++; $display("FAIL mid_rst_int: got %b want 0", bus.internal_int); end
    bus.inta_count = 2'd0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_edge();
    test_nesting();
    test_mask();
    test_aeoi_rotate();
    test_spurious();
    test_level();
    test_specific_eoi();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pic_irq_priority.md
Name: pic_irq_priority

Overview:
- Interrupt request/in-service/priority stage of the 8259-style PIC.
- Latches IR0–IR7 into the IRR and masks them with OCW1.
- Resolves priority against the ISR in fully-nested or rotating mode.
- Drives INTERNAL_INT and IR_NUM into Control_Unit; consumes Control_Unit's INTA_COUNT, AEOI, LEVEL, R and EOI commands.

Parameters:
- NUM_IR, 8, number of request lines (fixed at 8; 3-bit IR_NUM).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous active-high reset.
- IR  in  8  external interrupt request lines, synchronous to CLK.
- LEVEL  in  1  1 = level-triggered, 0 = edge-triggered (ICW1 LTIM).
- interrupt_mask  in  8  OCW1 mask; 1 = masked.
- R  in  1  1 = rotate priority on EOI/AEOI; 0 = fully nested.
- AEOI  in  1  automatic EOI at second INTA.
- INTA_COUNT  in  2  acknowledge phase from Control_Unit: 0 = idle, 1 = first INTA, 2 = second INTA.
- EOI_STB  in  1  one-cycle EOI command pulse (OCW2).
- EOI_SPECIFIC  in  1  1 = specific EOI.
- EOI_LEVEL  in  3  level for a specific EOI.
- INTERNAL_INT  out  1  interrupt request toward Control_Unit.
- IR_NUM  out  3  acknowledged level, held through the INTA sequence.
- IRR  out  8  interrupt request register (RIRR read).
- ISR  out  8  in-service register (RISR read).

Behaviour:
- Reset (async): IRR=0, ISR=0, IR_prev=0, IR_NUM=7, INTERNAL_INT=0, lowest-priority pointer LP=7 (IR0 highest), FSM=IDLE.
- IRR, edge mode: bit i sets on IR[i]==1 && IR_prev[i]==0.
- IRR, level mode: bit i follows IR[i].
- IRR, both modes:
  - Bit i clears at first-INTA latch when i is the winner.
  - Bit i clears when IR[i] falls before acknowledge.
  - Masking never clears IRR.
- Priority order: (LP+1) mod 8 is highest, LP is lowest.
- Candidate: highest-priority set bit of IRR & ~interrupt_mask.
- In-service level: highest-priority set bit of ISR.
- INTERNAL_INT (registered, 1-cycle latency) = 1 iff a candidate exists and it is strictly higher priority than any in-service level.
- FSM:
  - IDLE: on INTA_COUNT==1 go to FIRST.
    - If a candidate exists: IR_NUM ← candidate, ISR[candidate] ← 1, IRR[candidate] ← 0, INTERNAL_INT ← 0.
    - If none (spurious): IR_NUM ← 7, ISR unchanged.
  - FIRST: on INTA_COUNT==2 go to SECOND. If AEOI=1 and the ack was not spurious: clear ISR[IR_NUM]; if R=1, LP ← IR_NUM.
  - SECOND: on INTA_COUNT==0 go to IDLE. IR_NUM is held until the next first INTA.
  - Any state: INTA_COUNT==0 returns to IDLE without ISR changes (aborted sequence).
- EOI_STB, non-specific: clears the highest-priority ISR bit (no-op if ISR==0).
- EOI_STB, specific: clears ISR[EOI_LEVEL].
- EOI rotation: if R=1 and a bit was cleared, LP ← cleared level.
- Simultaneous EOI_STB and first-INTA latch: the EOI is applied to the pre-latch ISR; the latch set wins if both target the same bit.
- Mask change during FIRST/SECOND does not alter the latched IR_NUM or ISR.
- RESET mid-sequence: immediate return to reset values.

Decomposition:
- Shared include pic_defines.vh: FSM state encodings (IDLE, FIRST, SECOND), INTA_COUNT phase constants, spurious vector level 3'd7.
- Sub-module pic_prio_resolve8: combinational rotated find-first-set.
  - Inputs: 8-bit vector and LP.
  - Outputs: valid and 3-bit level.
  - Instanced twice, once for the candidate and once for the in-service level.

Test Plan:
- Edge, fully nested, mask=0: pulse IR=8'h24 → INTERNAL_INT=1 next cycle; INTA_COUNT 1 → IR_NUM=2, ISR=8'h04, IRR=8'h20, INTERNAL_INT=0; non-specific EOI → ISR=0, INTERNAL_INT reasserts for IR5.
- Nesting: ISR=8'h04 in service, raise IR1 → INTERNAL_INT=1; raise only IR6 → INTERNAL_INT stays 0.
- Masking: mask=8'h40, IR6 high → IRR=8'h40, INTERNAL_INT=0; unmask → INTERNAL_INT=1.
- AEOI + R=1: service IR3 → ISR=0 after INTA_COUNT=2, LP=3; then IR2 and IR4 raised together → IR_NUM=4.
- Spurious: raise IR5, drop it before INTA, INTA_COUNT 1 → IR_NUM=7, ISR=0. Level mode: IR held high after EOI → IRR re-sets and INTERNAL_INT reasserts.
- Specific EOI EOI_LEVEL=3 while ISR=8'h0A → ISR=8'h02. Assert RESET in FIRST → all outputs return to reset values immediately.
